// File: rtl/acc_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// acc_alu_seq_pkg
// Shared opcode definitions for the accumulator ALU and the instruction
// decoder. `OPCODE_WIDTH is the opcode field width; the OP_* constants are the
// operation encodings, extended in place with SHL, SHR and MUL so the decoder
// and the ALU agree.
// Optional feature macro: ACC_ALU_MUL_EN (OP_MUL is only executed when set).
// -----------------------------------------------------------------------------
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif

package acc_alu_seq_pkg;

   localparam int unsigned OPC_W = `OPCODE_WIDTH;

   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(9);

   // Step-counter width able to hold the value DATA_W itself.
   function automatic int unsigned step_cnt_w(input int unsigned data_w);
      return $clog2(data_w) + 1;
   endfunction

endpackage

// File: rtl/acc_alu_seq_mul.sv
// -----------------------------------------------------------------------------
// acc_alu_seq_mul
// Iterative shift-add multiplier, one multiplier bit per falling clock edge,
// DATA_W steps per operation.
// Ports:
//   clk, rst       clock (negedge active), async active-high reset
//   start          load operands (ignored while busy)
//   multiplicand   DATA_W operand
//   multiplier     DATA_W operand
//   busy           operation in progress (registered)
//   done           high during the last step, i.e. the coming negedge
//                  completes the product (combinational)
//   product        2*DATA_W product value as of the coming negedge; equals
//                  the final product while done is high
// -----------------------------------------------------------------------------
module acc_alu_seq_mul
   import acc_alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     multiplicand,
   input  logic [DATA_W-1:0]     multiplier,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int unsigned CNT_W = step_cnt_w(DATA_W);

   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   mplier;
   logic [CNT_W-1:0]    cnt;

   // Exposing the next partial product lets the owner commit the result on
   // the same edge as the final step instead of one edge later.
   assign product = prod + (mplier[0] ? mcand : '0);
   assign done    = busy && (cnt == CNT_W'(1));

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         prod   <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start && !busy) begin
         mcand  <= {{DATA_W{1'b0}}, multiplicand};
         prod   <= '0;
         mplier <= multiplier;
         cnt    <= CNT_W'(DATA_W);
         busy   <= 1'b1;
      end else if (busy) begin
         prod   <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/acc_alu_seq.sv
// -----------------------------------------------------------------------------
// acc_alu_seq
// Accumulator ALU with carry and zero flags. Single-cycle ADD/SUB/LD/AND/OR/
// XOR/NOT; multi-cycle SHL/SHR (one bit per cycle) and optional MUL, with a
// busy/done handshake. All state changes on the falling edge of clk.
// Optional feature macro: ACC_ALU_MUL_EN (adds MUL state and multiplier).
// Ports:
//   clk       clock, state updates on negedge
//   rst       asynchronous active-high reset
//   alu_ce    execute strobe, sampled on negedge (ignored while busy)
//   cy_ce     ADD/SUB use cy as carry/borrow-in
//   opcode    operation select (OP_* in acc_alu_seq_pkg)
//   register  operand from register file
//   acc       accumulator (registered)
//   cy        carry/borrow/shift-out/overflow flag (registered)
//   zero      acc == 0 (combinational)
//   busy      multi-cycle op in progress (registered)
//   done      one-cycle pulse on the edge a result is written (registered)
// -----------------------------------------------------------------------------
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif

module acc_alu_seq
   import acc_alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned OPCODE_W = `OPCODE_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_ce,
   input  logic                cy_ce,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [DATA_W-1:0]   register,
   output logic [DATA_W-1:0]   acc,
   output logic                cy,
   output logic                zero,
   output logic                busy,
   output logic                done
);

   localparam int unsigned      CNT_W = step_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(DATA_W);

   typedef enum logic [1:0] {
      IDLE,
`ifdef ACC_ALU_MUL_EN
      MUL,
`endif
      SHIFT
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] acc_nxt;
   logic              cy_nxt, busy_nxt, done_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              shl, shl_nxt;

   logic [DATA_W:0]   cin, sum, diff;
   logic [CNT_W-1:0]  reg_n, shift_n;

   assign cin     = (DATA_W+1)'(cy_ce & cy);
   assign sum     = {1'b0, acc} + {1'b0, register} + cin;
   // Top bit of the widened difference is the borrow.
   assign diff    = {1'b0, acc} - {1'b0, register} - cin;
   assign reg_n   = register[CNT_W-1:0];
   assign shift_n = (reg_n > MAX_N) ? MAX_N : reg_n;
   assign zero    = (acc == '0);

`ifdef ACC_ALU_MUL_EN
   logic                mul_start, mul_busy, mul_done;
   logic [2*DATA_W-1:0] mul_product;

   acc_alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
      .clk          (clk),
      .rst          (rst),
      .start        (mul_start),
      .multiplicand (acc),
      .multiplier   (register),
      .busy         (mul_busy),
      .done         (mul_done),
      .product      (mul_product)
   );
`endif

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cy_nxt    = cy;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      cnt_nxt   = cnt;
      shl_nxt   = shl;
`ifdef ACC_ALU_MUL_EN
      mul_start = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (alu_ce) begin
               done_nxt = 1'b1;
               cy_nxt   = 1'b0;
               case (opcode)
                  OP_ADD: {cy_nxt, acc_nxt} = sum;
                  OP_SUB: {cy_nxt, acc_nxt} = diff;
                  OP_LD:  acc_nxt = register;
                  OP_AND: acc_nxt = acc & register;
                  OP_OR:  acc_nxt = acc | register;
                  OP_XOR: acc_nxt = acc ^ register;
                  OP_NOT: acc_nxt = ~register;
                  OP_SHL, OP_SHR: begin
                     if (shift_n != '0) begin
                        cnt_nxt   = shift_n;
                        shl_nxt   = (opcode == OP_SHL);
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        state_nxt = SHIFT;
                     end
                  end
`ifdef ACC_ALU_MUL_EN
                  OP_MUL: begin
                     if (!mul_busy) begin
                        mul_start = 1'b1;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        state_nxt = MUL;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
         SHIFT: begin
            if (shl) begin
               cy_nxt  = acc[DATA_W-1];
               acc_nxt = {acc[DATA_W-2:0], 1'b0};
            end else begin
               cy_nxt  = acc[0];
               acc_nxt = {1'b0, acc[DATA_W-1:1]};
            end
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
`ifdef ACC_ALU_MUL_EN
         MUL: begin
            if (mul_done) begin
               acc_nxt   = mul_product[DATA_W-1:0];
               cy_nxt    = |mul_product[2*DATA_W-1:DATA_W];
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cy    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         shl   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cy    <= cy_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         cnt   <= cnt_nxt;
         shl   <= shl_nxt;
      end
   end

endmodule

// File: tb/tb_acc_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_acc_alu_seq
// Self-checking bench for acc_alu_seq (DATA_W=8). Honours ACC_ALU_MUL_EN.
// -----------------------------------------------------------------------------
module tb_acc_alu_seq;
   import acc_alu_seq_pkg::*;

   localparam int W    = 8;
   localparam int CW   = $clog2(W) + 1;
   localparam int MASK = (1 << W) - 1;

   typedef logic [`OPCODE_WIDTH-1:0] op_t;

   logic         clk = 1'b0, rst = 1'b0, alu_ce = 1'b0, cy_ce = 1'b0;
   op_t          opcode = '0;
   logic [W-1:0] register = '0;
   logic [W-1:0] acc;
   logic         cy, zero, busy, done;

   int errors = 0;
   int checks = 0;
   bit run_chk = 1'b0;

   always #5 clk = ~clk;

   acc_alu_seq #(.DATA_W(W), .OPCODE_W(`OPCODE_WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .alu_ce   (alu_ce),
      .cy_ce    (cy_ce),
      .opcode   (opcode),
      .register (register),
      .acc      (acc),
      .cy       (cy),
      .zero     (zero),
      .busy     (busy),
      .done     (done)
   );

   // Transaction-level model: multi-cycle ops record the start value and the
   // expected outputs at step k are computed arithmetically from it.
   typedef struct packed {
      int acc; int cy; int busy; int done;
      int left; int k; int base; int kind;   // kind: 0 SHL, 1 SHR, 2 MUL
   } model_t;

   model_t m;

   function automatic model_t model_step(model_t s, bit ce, op_t op, int r, bit cc);
      model_t n;
      int t, sh, cin;
      n = s;
      n.done = 0;
      if (s.left > 0) begin
         n.k    = s.k + 1;
         n.left = s.left - 1;
         case (s.kind)
            0: begin
               n.acc = (s.base << n.k) & MASK;
               n.cy  = (s.base >> (W - n.k)) & 1;
            end
            1: begin
               n.acc = s.base >> n.k;
               n.cy  = (s.base >> (n.k - 1)) & 1;
            end
            default: if (n.left == 0) begin
               n.acc = s.base & MASK;
               n.cy  = ((s.base >> W) != 0) ? 1 : 0;
            end
         endcase
         if (n.left == 0) begin
            n.busy = 0;
            n.done = 1;
         end
      end else if (ce) begin
         n.done = 1;
         n.cy   = 0;
         cin    = cc ? s.cy : 0;
         case (op)
            OP_ADD: begin t = s.acc + r + cin; n.acc = t & MASK; n.cy = t >> W; end
            OP_SUB: begin t = s.acc - r - cin; n.acc = t & MASK; n.cy = (t < 0) ? 1 : 0; end
            OP_LD:  n.acc = r;
            OP_AND: n.acc = s.acc & r;
            OP_OR:  n.acc = s.acc | r;
            OP_XOR: n.acc = s.acc ^ r;
            OP_NOT: n.acc = ~r & MASK;
            OP_SHL, OP_SHR: begin
               sh = r & ((1 << CW) - 1);
               if (sh > W) sh = W;
               if (sh > 0) begin
                  n.busy = 1; n.done = 0; n.left = sh; n.k = 0;
                  n.base = s.acc; n.kind = (op == OP_SHL) ? 0 : 1;
               end
            end
`ifdef ACC_ALU_MUL_EN
            OP_MUL: begin
               n.busy = 1; n.done = 0; n.left = W; n.k = 0;
               n.base = s.acc * r; n.kind = 2;
            end
`endif
            default: ;
         endcase
      end
      return n;
   endfunction

   always @(negedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= model_step(m, alu_ce, opcode, int'(register), cy_ce);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Outputs are stable between falling edges; compare on every rising edge.
   always @(posedge clk) begin
      if (run_chk && !rst) begin
         chk("cmp.acc",  int'(acc),  m.acc);
         chk("cmp.cy",   int'(cy),   m.cy);
         chk("cmp.zero", int'(zero), (m.acc == 0) ? 1 : 0);
         chk("cmp.busy", int'(busy), m.busy);
         chk("cmp.done", int'(done), m.done);
      end
   end

   // Hand-computed expectations for DUT and model alike.
   task automatic pin(input string name, input int e_acc, input int e_cy,
                      input int e_busy, input int e_done);
      chk({name, ".acc"},  int'(acc),  e_acc);
      chk({name, ".cy"},   int'(cy),   e_cy);
      chk({name, ".busy"}, int'(busy), e_busy);
      chk({name, ".done"}, int'(done), e_done);
      chk({name, ".zero"}, int'(zero), (e_acc == 0) ? 1 : 0);
      if (!rst) chk({name, ".model"}, m.acc, e_acc);
   endtask

   // Called just after a rising edge; the following falling edge samples.
   task automatic issue(input bit ce, input op_t op, input int r, input bit cc);
      alu_ce   = ce;
      opcode   = op;
      register = r[W-1:0];
      cy_ce    = cc;
      @(posedge clk);
      #1;
      alu_ce = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) issue(1'b0, OP_ADD, 0, 1'b0);
   endtask

   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      op_t rop;
      bit  rce, rcc;
      int  rr;

      #1 rst = 1'b1;
      #1;
      pin("reset0", 0, 0, 0, 0);
      release_reset();
      run_chk = 1'b1;

      // Async reset with non-zero state
      issue(1, OP_LD, 'h5A, 0);
      issue(1, OP_ADD, 'hC0, 0);
      pin("pre_rst", 'h1A, 1, 0, 1);
      mid_reset();
      pin("async_rst", 0, 0, 0, 0);
      release_reset();

      // Carry chain, cy preserved over idle cycles
      issue(1, OP_LD, 'hF0, 0);
      issue(1, OP_ADD, 'h20, 0);
      pin("add_carry", 'h10, 1, 0, 1);
      idle(3);
      pin("idle_keep", 'h10, 1, 0, 0);
      issue(1, OP_ADD, 'h00, 1);
      pin("add_cin", 'h11, 0, 0, 1);

      // Borrow
      issue(1, OP_LD, 'h05, 0);
      issue(1, OP_SUB, 'h07, 0);
      pin("sub_borrow", 'hFE, 1, 0, 1);
      issue(1, OP_SUB, 'hFE, 0);
      pin("sub_zero", 'h00, 0, 0, 1);

      // SHL by 3 with an ADD issued while busy
      issue(1, OP_LD, 'h81, 0);
      issue(1, OP_SHL, 3, 0);
      pin("shl_issue", 'h81, 0, 1, 0);
      issue(1, OP_ADD, 'hFF, 0);
      pin("shl_s1", 'h02, 1, 1, 0);
      idle(1);
      pin("shl_s2", 'h04, 0, 1, 0);
      idle(1);
      pin("shl_s3", 'h08, 0, 0, 1);

      // SHR clamped to DATA_W steps
      issue(1, OP_LD, 'hFF, 0);
      issue(1, OP_SHR, 9, 0);
      idle(7);
      pin("shr_s7", 'h01, 1, 1, 0);
      idle(1);
      pin("shr_s8", 'h00, 1, 0, 1);

      // Zero shift count
      issue(1, OP_LD, 'h33, 0);
      issue(1, OP_SHL, 'h30, 0);
      pin("shl_zero", 'h33, 0, 0, 1);

      // Reset mid-operation aborts without commit
      issue(1, OP_LD, 'h01, 0);
      issue(1, OP_SHL, 6, 0);
      idle(2);
      pin("shl6_s2", 'h04, 0, 1, 0);
      mid_reset();
      pin("rst_midop", 0, 0, 0, 0);
      release_reset();
      idle(3);
      pin("post_rst", 0, 0, 0, 0);
      issue(1, OP_LD, 'h3C, 0);
      pin("ld_after", 'h3C, 0, 0, 1);

      // Undefined opcode clears cy, holds acc
      issue(1, OP_LD, 'hFF, 0);
      issue(1, OP_ADD, 'h01, 0);
      pin("wrap", 'h00, 1, 0, 1);
      issue(1, op_t'(15), 'hAA, 0);
      pin("undef_op", 'h00, 0, 0, 1);

      // Multiply
      issue(1, OP_LD, 'h10, 0);
      issue(1, OP_MUL, 'h12, 0);
`ifdef ACC_ALU_MUL_EN
      pin("mul_issue", 'h10, 0, 1, 0);
      idle(7);
      pin("mul_s7", 'h10, 0, 1, 0);
      idle(1);
      pin("mul_done", 'h20, 1, 0, 1);
`else
      pin("mul_undef", 'h10, 0, 0, 1);
      idle(1);
      pin("mul_undef_idle", 'h10, 0, 0, 0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rce = ($urandom_range(0, 9) < 7);
         rop = op_t'($urandom_range(0, 15));
         rr  = $urandom_range(0, 255);
         if ((rop == OP_SHL || rop == OP_SHR) && $urandom_range(0, 1) == 1)
            rr = $urandom_range(0, 15);
         rcc = 1'($urandom_range(0, 1));
         issue(rce, rop, rr, rcc);
      end
      idle(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
